// File: rtl/imba_menu_controller.sv
// rtl/imba_menu_controller.sv - welcome screen, settings menu, cursor and overlay enable sequencing
module imba_menu_controller #(
  parameter int WELCOME_CYCLES = 25_000_000,
  parameter int MENU_TIMEOUT   = 250_000_000,
  parameter int CNT_W          = 28
) (
  input  logic       CLK_VGA,
  input  logic       RESET_N,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic       BTN_CENTRE,
  input  logic       BTN_LEFT,
  output logic       Welcome_Active,
  output logic       Menu_Active,
  output logic [1:0] Cursor_Idx,
  output logic       Axis_On,
  output logic       Tick_On,
  output logic       Grid_On
);

  typedef enum logic [1:0] {
    ST_WELCOME = 2'd0,
    ST_RUN     = 2'd1,
    ST_MENU    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WELCOME_LAST = CNT_W'(WELCOME_CYCLES - 1);
  localparam logic [CNT_W-1:0] MENU_LAST    = CNT_W'(MENU_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX    = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt, timer_inc;
  logic [1:0]       cursor, cursor_nxt;
  logic             axis, axis_nxt;
  logic             tick, tick_nxt;
  logic             grid, grid_nxt;
  logic             welcome_q, menu_q;

  // Buttons packed as {left, centre, up, down}; history regs give the rising-edge presses.
  logic [3:0] btn, btn_d, press;
  logic       any_press, p_left, p_centre, p_up, p_down;

  assign btn       = {BTN_LEFT, BTN_CENTRE, BTN_UP, BTN_DOWN};
  assign press     = btn & ~btn_d;
  assign any_press = |press;
  // One action per cycle: LEFT beats CENTRE beats UP beats DOWN.
  assign p_left    = press[3];
  assign p_centre  = press[2] & ~press[3];
  assign p_up      = press[1] & ~(|press[3:2]);
  assign p_down    = press[0] & ~(|press[3:1]);

  // The shared timer stops at all-ones rather than wrapping.
  assign timer_inc = (timer == TIMER_MAX) ? timer : timer + CNT_W'(1);

  // State, timer, cursor, enables and the two activity flags all update on the same edge.
  always_ff @(posedge CLK_VGA or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_WELCOME;
      timer     <= '0;
      cursor    <= 2'd0;
      axis      <= 1'b1;
      tick      <= 1'b1;
      grid      <= 1'b0;
      welcome_q <= 1'b1;
      menu_q    <= 1'b0;
      btn_d     <= 4'b0000;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      cursor    <= cursor_nxt;
      axis      <= axis_nxt;
      tick      <= tick_nxt;
      grid      <= grid_nxt;
      welcome_q <= (state_nxt == ST_WELCOME);
      menu_q    <= (state_nxt == ST_MENU);
      btn_d     <= btn;
    end
  end

  // Next-state logic: welcome hold, menu entry from RUN, cursor moves, toggles and timeouts.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    cursor_nxt = cursor;
    axis_nxt   = axis;
    tick_nxt   = tick;
    grid_nxt   = grid;
    case (state)
      ST_WELCOME: begin
        if (any_press || timer == WELCOME_LAST) begin
          state_nxt = ST_RUN;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer_inc;
        end
      end
      ST_RUN: begin
        if (p_centre) begin
          state_nxt  = ST_MENU;
          cursor_nxt = 2'd0;
          timer_nxt  = '0;
        end
      end
      ST_MENU: begin
        if (any_press) begin
          timer_nxt = '0;
        end else if (timer == MENU_LAST) begin
          state_nxt = ST_RUN;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer_inc;
        end
        if (p_left) begin
          state_nxt = ST_RUN;
        end else if (p_centre) begin
          case (cursor)
            2'd0:    axis_nxt  = ~axis;
            2'd1:    tick_nxt  = ~tick;
            2'd2:    grid_nxt  = ~grid;
            default: state_nxt = ST_RUN;
          endcase
        end else if (p_up) begin
          cursor_nxt = cursor - 2'd1;
        end else if (p_down) begin
          cursor_nxt = cursor + 2'd1;
        end
      end
      default: begin
        state_nxt = ST_WELCOME;
        timer_nxt = '0;
      end
    endcase
  end

  assign Welcome_Active = welcome_q;
  assign Menu_Active    = menu_q;
  assign Cursor_Idx     = cursor;
  assign Axis_On        = axis;
  assign Tick_On        = tick;
  assign Grid_On        = grid;

endmodule

// File: tb/tb_imba_menu_controller.sv
// tb/tb_imba_menu_controller.sv - self-checking bench for imba_menu_controller
module tb_imba_menu_controller;

  localparam int WC = 16;
  localparam int MT = 8;
  localparam int CW = 8;
  localparam logic [6:0] RESET_OUTS = 7'b1000110;

  logic       CLK_VGA = 1'b0;
  logic       RESET_N = 1'b0;
  logic       BTN_UP = 1'b0, BTN_DOWN = 1'b0, BTN_CENTRE = 1'b0, BTN_LEFT = 1'b0;
  logic       Welcome_Active, Menu_Active;
  logic [1:0] Cursor_Idx;
  logic       Axis_On, Tick_On, Grid_On;

  imba_menu_controller #(
    .WELCOME_CYCLES(WC),
    .MENU_TIMEOUT  (MT),
    .CNT_W         (CW)
  ) dut (
    .CLK_VGA       (CLK_VGA),
    .RESET_N       (RESET_N),
    .BTN_UP        (BTN_UP),
    .BTN_DOWN      (BTN_DOWN),
    .BTN_CENTRE    (BTN_CENTRE),
    .BTN_LEFT      (BTN_LEFT),
    .Welcome_Active(Welcome_Active),
    .Menu_Active   (Menu_Active),
    .Cursor_Idx    (Cursor_Idx),
    .Axis_On       (Axis_On),
    .Tick_On       (Tick_On),
    .Grid_On       (Grid_On)
  );

  always #5 CLK_VGA = ~CLK_VGA;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 welcome, 1 run, 2 menu; m_timer counts elapsed idle cycles.
  int         m_mode, m_timer, m_cursor;
  logic       m_en [3];
  logic [3:0] m_prev;

  typedef struct {
    logic [3:0] btn;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs [26];

  // Output bundle {welcome, menu, cursor, axis, tick, grid}.
  function automatic logic [6:0] outs();
    return {Welcome_Active, Menu_Active, Cursor_Idx, Axis_On, Tick_On, Grid_On};
  endfunction

  function automatic logic [6:0] model_exp();
    return {m_mode == 0, m_mode == 2, 2'(m_cursor), m_en[0], m_en[1], m_en[2]};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (W M cur A T G)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_timer  = 0;
    m_cursor = 0;
    m_en[0]  = 1'b1;
    m_en[1]  = 1'b1;
    m_en[2]  = 1'b0;
    m_prev   = 4'b0000;
  endtask

  // b is {left, centre, up, down}; the highest newly-pressed bit is the one action taken.
  task automatic model_step(input logic [3:0] b);
    logic [3:0] newly;
    int         act;
    newly  = b & ~m_prev;
    m_prev = b;
    act    = -1;
    for (int i = 3; i >= 0; i--) if (newly[i] && act < 0) act = i;
    case (m_mode)
      0: begin
        m_timer++;
        if (act >= 0 || m_timer == WC) begin
          m_mode  = 1;
          m_timer = 0;
        end
      end
      1: begin
        if (act == 2) begin
          m_mode   = 2;
          m_cursor = 0;
          m_timer  = 0;
        end
      end
      default: begin
        if (act < 0) begin
          m_timer++;
          if (m_timer == MT) begin
            m_mode  = 1;
            m_timer = 0;
          end
        end else begin
          m_timer = 0;
          case (act)
            3: m_mode = 1;
            2: if (m_cursor == 3) m_mode = 1; else m_en[m_cursor] = ~m_en[m_cursor];
            1: m_cursor = (m_cursor + 3) % 4;
            default: m_cursor = (m_cursor + 1) % 4;
          endcase
        end
      end
    endcase
  endtask

  task automatic set_btn(input logic [3:0] b);
    {BTN_LEFT, BTN_CENTRE, BTN_UP, BTN_DOWN} = b;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic tick(input logic [3:0] b);
    set_btn(b);
    @(posedge CLK_VGA);
    model_step(b);
    #1;
    check("model", outs(), model_exp());
  endtask

  // Asynchronous reset pulse placed between clock edges, with an immediate output check.
  task automatic do_reset(input logic [3:0] hold);
    set_btn(hold);
    #2 RESET_N = 1'b0;
    #1 check("reset_async", outs(), RESET_OUTS);
    #3 RESET_N = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0]  = '{4'b0000, 7'b1000110};
    vecs[1]  = '{4'b0000, 7'b1000110};
    vecs[2]  = '{4'b0001, 7'b0000110};
    vecs[3]  = '{4'b0000, 7'b0000110};
    vecs[4]  = '{4'b0100, 7'b0100110};
    vecs[5]  = '{4'b0000, 7'b0100110};
    vecs[6]  = '{4'b0010, 7'b0111110};
    vecs[7]  = '{4'b0000, 7'b0111110};
    vecs[8]  = '{4'b0001, 7'b0100110};
    vecs[9]  = '{4'b0000, 7'b0100110};
    vecs[10] = '{4'b0001, 7'b0101110};
    vecs[11] = '{4'b0000, 7'b0101110};
    vecs[12] = '{4'b0100, 7'b0101100};
    vecs[13] = '{4'b0000, 7'b0101100};
    vecs[14] = '{4'b0001, 7'b0110100};
    vecs[15] = '{4'b0000, 7'b0110100};
    vecs[16] = '{4'b0110, 7'b0110101};
    vecs[17] = '{4'b0000, 7'b0110101};
    vecs[18] = '{4'b1100, 7'b0010101};
    vecs[19] = '{4'b0000, 7'b0010101};
    vecs[20] = '{4'b0100, 7'b0100101};
    vecs[21] = '{4'b0000, 7'b0100101};
    vecs[22] = '{4'b0010, 7'b0111101};
    vecs[23] = '{4'b0000, 7'b0111101};
    vecs[24] = '{4'b0100, 7'b0011101};
    vecs[25] = '{4'b0000, 7'b0011101};

    @(posedge CLK_VGA);
    #1;
    do_reset(4'b0000);

    // Idle welcome length
    n = 0;
    while (Welcome_Active === 1'b1 && n < 100) begin
      tick(4'b0000);
      n++;
    end
    check_int("welcome_len", n, WC);
    check("after_welcome", outs(), 7'b0000110);

    // Directed vectors: early exit by press, cursor wrap, toggles, coincident presses
    do_reset(4'b0000);
    for (int i = 0; i < 26; i++) begin
      tick(vecs[i].btn);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Menu idle timeout
    tick(4'b0100);
    n = 0;
    while (Menu_Active === 1'b1 && n < 100) begin
      tick(4'b0000);
      n++;
    end
    check_int("menu_timeout", n, MT);

    // Press on the 7th idle cycle restarts the timeout
    tick(4'b0100);
    repeat (6) tick(4'b0000);
    tick(4'b0001);
    n = 0;
    while (Menu_Active === 1'b1 && n < 100) begin
      tick(4'b0000);
      n++;
    end
    check_int("menu_restart", n, MT);

    // Reset mid-menu with Grid_On=1, centre held through reset
    tick(4'b0100);
    tick(4'b0000);
    tick(4'b0001);
    tick(4'b0000);
    tick(4'b0001);
    tick(4'b0000);
    tick(4'b0100);
    tick(4'b0000);
    tick(4'b0100);
    check("pre_reset", outs(), 7'b0110101);
    do_reset(4'b0100);
    tick(4'b0100);
    check("held_centre", outs(), 7'b0000110);

    // Random traffic against the model
    do_reset(4'b0000);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r == 0) begin
        do_reset(4'($urandom_range(0, 15)));
      end else if (r < 8) begin
        repeat ($urandom_range(1, 12)) tick(4'b0000);
      end else begin
        tick(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
